// File: rtl/net_msg_endpoint_if.sv
// Messenger-side and link-side signal bundle of the network message endpoint.
// The endpoint uses the slave view; whoever drives the Messenger and the link uses the master view.
interface net_msg_endpoint_if;
    logic         NETSEND;
    logic [79:0]  NETMSG;
    logic         NETTYPE;
    logic [4:0]   NETSTAT;
    logic         NETRDY;
    logic         NETREQ;
    logic [121:0] NETPARAM;
    logic         NETMSGRD;
    logic [31:0]  TXD;
    logic         TXSOF;
    logic         TXVAL;
    logic         TXRDY;
    logic [31:0]  RXD;
    logic         RXSOF;
    logic         RXVAL;
    logic         RXRDY;
    logic         TXOVR;
    logic [7:0]   RXERRCNT;

    modport slave (
        input  NETSEND, NETMSG, NETTYPE, NETSTAT, NETMSGRD, TXRDY, RXD, RXSOF, RXVAL,
        output NETRDY, NETREQ, NETPARAM, TXD, TXSOF, TXVAL, RXRDY, TXOVR, RXERRCNT
    );

    modport master (
        output NETSEND, NETMSG, NETTYPE, NETSTAT, NETMSGRD, TXRDY, RXD, RXSOF, RXVAL,
        input  NETRDY, NETREQ, NETPARAM, TXD, TXSOF, TXVAL, RXRDY, TXOVR, RXERRCNT
    );
endinterface

// File: rtl/net_msg_endpoint.sv
// Network-controller end of the Messenger interface: serialises outbound messages as 3-word link
// frames and assembles inbound 4-word link frames into records queued for the Messenger.
module net_msg_endpoint #(
    parameter int FIFO_DEPTH = 4
) (
    input logic               CLK,
    input logic               RESET,
    net_msg_endpoint_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_W0, TX_W1, TX_W2} txState_t;

    txState_t     txState_q, txState_d;
    logic [79:0]  msg_q, msg_d;
    logic         type_q, type_d;
    logic [4:0]   stat_q, stat_d;
    logic         netRdy_q, netRdy_d;
    logic         txOvr_q, txOvr_d;
    logic [31:0]  txData;
    logic         txXfer;

    logic [1:0]   wc_q, wc_d;
    logic [89:0]  rec_q, rec_d;
    logic [7:0]   errCnt_q, errCnt_d;
    logic [121:0] mem_q [FIFO_DEPTH];
    logic [121:0] head_q, head_d;
    logic [121:0] wrData;
    logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [AW:0]  count_q, count_d;
    logic         rxRdy, rxAccept, errInc, push, pop;
    logic         unusedRxBits;

    always_comb begin
        txState_d = txState_q;
        msg_d     = msg_q;
        type_d    = type_q;
        stat_d    = stat_q;
        netRdy_d  = 1'b0;
        txOvr_d   = txOvr_q;
        txData    = '0;
        txXfer    = (txState_q != TX_IDLE) && bus.TXRDY;
        case (txState_q)
            TX_IDLE: begin
                if (bus.NETSEND) begin
                    msg_d     = bus.NETMSG;
                    type_d    = bus.NETTYPE;
                    stat_d    = bus.NETSTAT;
                    txState_d = TX_W0;
                end
            end
            TX_W0: begin
                txData = {type_q, 10'd0, stat_q, msg_q[47:32]};
                if (txXfer) txState_d = TX_W1;
            end
            TX_W1: begin
                txData = msg_q[31:0];
                if (txXfer) txState_d = TX_W2;
            end
            TX_W2: begin
                txData = msg_q[79:48];
                if (txXfer) begin
                    txState_d = TX_IDLE;
                    netRdy_d  = 1'b1;
                end
            end
            default: txState_d = TX_IDLE;
        endcase
        // A message offered mid-frame is dropped; only the sticky flag records it.
        if (bus.NETSEND && (txState_q != TX_IDLE)) txOvr_d = 1'b1;
    end

    always_comb begin
        wc_d     = wc_q;
        rec_d    = rec_q;
        push     = 1'b0;
        errInc   = 1'b0;
        wrData   = {rec_q, bus.RXD};
        rxRdy    = (count_q != FULL_COUNT);
        rxAccept = bus.RXVAL && rxRdy;
        if (rxAccept) begin
            if (bus.RXSOF) begin
                errInc        = (wc_q != 2'd0);
                rec_d[89:64]  = bus.RXD[25:0];
                wc_d          = 2'd1;
            end else begin
                case (wc_q)
                    2'd0: errInc = 1'b1;
                    2'd1: begin rec_d[63:32] = bus.RXD; wc_d = 2'd2; end
                    2'd2: begin rec_d[31:0]  = bus.RXD; wc_d = 2'd3; end
                    default: begin push = 1'b1; wc_d = 2'd0; end
                endcase
            end
        end
        errCnt_d = (errInc && (errCnt_q != 8'hFF)) ? errCnt_q + 8'd1 : errCnt_q;

        pop     = bus.NETMSGRD && (count_q != '0);
        wrPtr_d = push ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // The head register must see a record written this cycle if it lands at the new read slot.
        head_d = (push && (wrPtr_q == rdPtr_d)) ? wrData : mem_q[rdPtr_d];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            txState_q <= TX_IDLE;
            msg_q     <= '0;
            type_q    <= 1'b0;
            stat_q    <= '0;
            netRdy_q  <= 1'b0;
            txOvr_q   <= 1'b0;
            wc_q      <= '0;
            rec_q     <= '0;
            errCnt_q  <= '0;
            head_q    <= '0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
        end else begin
            txState_q <= txState_d;
            msg_q     <= msg_d;
            type_q    <= type_d;
            stat_q    <= stat_d;
            netRdy_q  <= netRdy_d;
            txOvr_q   <= txOvr_d;
            wc_q      <= wc_d;
            rec_q     <= rec_d;
            errCnt_q  <= errCnt_d;
            head_q    <= head_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && push) mem_q[wrPtr_q] <= wrData;
    end

    assign unusedRxBits = ^bus.RXD[31:26];

    assign bus.TXD      = txData;
    assign bus.TXSOF    = (txState_q == TX_W0);
    assign bus.TXVAL    = (txState_q != TX_IDLE);
    assign bus.NETRDY   = netRdy_q;
    assign bus.TXOVR    = txOvr_q;
    assign bus.RXRDY    = rxRdy;
    assign bus.RXERRCNT = errCnt_q;
    assign bus.NETREQ   = (count_q != '0);
    assign bus.NETPARAM = head_q;
endmodule

// File: tb/tb_net_msg_endpoint.sv
// Directed bench for net_msg_endpoint: outbound framing, inbound assembly, FIFO back-pressure,
// reset abandonment and error/overrun flags, each against hand-computed values.
module tb_net_msg_endpoint;
    logic clk = 1'b0;
    logic reset;
    int   compareCount  = 0;
    int   mismatchCount = 0;

    always #5 clk = ~clk;

    net_msg_endpoint_if bus();

    net_msg_endpoint #(.FIFO_DEPTH(4)) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus.slave)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [79:0] msg, input logic typ, input logic [4:0] stat);
        bus.NETMSG  = msg;
        bus.NETTYPE = typ;
        bus.NETSTAT = stat;
        bus.NETSEND = 1'b1;
        tick();
        bus.NETSEND = 1'b0;
    endtask

    task automatic popHead();
        bus.NETMSGRD = 1'b1;
        tick();
        bus.NETMSGRD = 1'b0;
    endtask

    task automatic sendRxWord(input logic [31:0] d, input logic sof);
        int waitCycles = 0;
        bus.RXD   = d;
        bus.RXSOF = sof;
        bus.RXVAL = 1'b1;
        while (!bus.RXRDY && waitCycles < 50) begin
            tick();
            waitCycles++;
        end
        if (!bus.RXRDY) checkOutput("rxrdy_timeout", 1'b0, 1'b1);
        tick();
        bus.RXVAL = 1'b0;
        bus.RXSOF = 1'b0;
    endtask

    // Top six bits of word0 are deliberately non-zero so that dropping them is exercised.
    function automatic logic [31:0] frameWord(input int k, input int i);
        return {8'(8'hC0 + k), 8'(i), 16'(k * 257 + i * 17)};
    endfunction

    function automatic logic [121:0] frameRec(input int k);
        logic [31:0] w0;
        w0 = frameWord(k, 0);
        return {w0[25:0], frameWord(k, 1), frameWord(k, 2), frameWord(k, 3)};
    endfunction

    task automatic sendRxFrame(input int k);
        for (int i = 0; i < 4; i++) sendRxWord(frameWord(k, i), (i == 0));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [79:0] msgA;
        logic [79:0] msgB;

        bus.NETSEND  = 1'b0;
        bus.NETMSG   = '0;
        bus.NETTYPE  = 1'b0;
        bus.NETSTAT  = '0;
        bus.NETMSGRD = 1'b0;
        bus.TXRDY    = 1'b0;
        bus.RXD      = '0;
        bus.RXSOF    = 1'b0;
        bus.RXVAL    = 1'b0;
        reset        = 1'b1;
        tick();
        tick();
        checkOutput("rst_txval",  bus.TXVAL,    1'b0);
        checkOutput("rst_txd",    bus.TXD,      32'h0);
        checkOutput("rst_txsof",  bus.TXSOF,    1'b0);
        checkOutput("rst_netrdy", bus.NETRDY,   1'b0);
        checkOutput("rst_netreq", bus.NETREQ,   1'b0);
        checkOutput("rst_param",  bus.NETPARAM, 122'h0);
        checkOutput("rst_rxrdy",  bus.RXRDY,    1'b1);
        checkOutput("rst_txovr",  bus.TXOVR,    1'b0);
        checkOutput("rst_errcnt", bus.RXERRCNT, 8'h0);
        reset = 1'b0;

        $display("[TB] reset mid-frame");
        bus.TXRDY = 1'b1;
        applyStimulus({32'hDEAD0000, 16'h0077, 32'h55667788}, 1'b0, 5'h0);
        tick();
        bus.TXRDY = 1'b0;
        checkOutput("t1_in_w1", bus.TXD, 32'h55667788);
        sendRxWord(frameWord(9, 0), 1'b1);
        sendRxWord(frameWord(9, 1), 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t1_txval", bus.TXVAL,  1'b0);
        checkOutput("t1_netreq", bus.NETREQ, 1'b0);
        checkOutput("t1_rxrdy", bus.RXRDY,  1'b1);
        bus.TXRDY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t1_no_netrdy", bus.NETRDY, 1'b0);
        end
        sendRxFrame(1);
        checkOutput("t1_fresh_req",   bus.NETREQ,   1'b1);
        checkOutput("t1_fresh_param", bus.NETPARAM, frameRec(1));
        checkOutput("t1_errcnt",      bus.RXERRCNT, 8'h0);
        popHead();
        checkOutput("t1_popped", bus.NETREQ, 1'b0);

        $display("[TB] outbound request");
        applyStimulus({32'hCAFE0001, 16'h0012, 32'h00010203}, 1'b0, 5'h0);
        checkOutput("t2_w0_val", bus.TXVAL, 1'b1);
        checkOutput("t2_w0_sof", bus.TXSOF, 1'b1);
        checkOutput("t2_w0_d",   bus.TXD,   32'h00000012);
        tick();
        checkOutput("t2_w1_sof", bus.TXSOF, 1'b0);
        checkOutput("t2_w1_d",   bus.TXD,   32'h00010203);
        tick();
        checkOutput("t2_w2_d",      bus.TXD,    32'hCAFE0001);
        checkOutput("t2_w2_netrdy", bus.NETRDY, 1'b0);
        tick();
        checkOutput("t2_netrdy", bus.NETRDY, 1'b1);
        checkOutput("t2_idle",   bus.TXVAL,  1'b0);
        tick();
        checkOutput("t2_netrdy_pulse", bus.NETRDY, 1'b0);

        $display("[TB] outbound reply with link stall");
        applyStimulus({32'h11112222, 16'h0000, 32'h33334444}, 1'b1, 5'h1F);
        checkOutput("t3_w0_d", bus.TXD, 32'h801F0000);
        tick();
        bus.TXRDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t3_stall_d",   bus.TXD,    32'h33334444);
            checkOutput("t3_stall_val", bus.TXVAL,  1'b1);
            checkOutput("t3_stall_rdy", bus.NETRDY, 1'b0);
        end
        bus.TXRDY = 1'b1;
        tick();
        checkOutput("t3_w2_d", bus.TXD, 32'h11112222);
        tick();
        checkOutput("t3_netrdy", bus.NETRDY, 1'b1);

        $display("[TB] inbound frame");
        sendRxWord(32'h03ABCDEF, 1'b1);
        sendRxWord(32'h00070009, 1'b0);
        sendRxWord(32'h12345678, 1'b0);
        checkOutput("t4_partial_req", bus.NETREQ, 1'b0);
        sendRxWord(32'h00AA0055, 1'b0);
        checkOutput("t4_req", bus.NETREQ, 1'b1);
        checkOutput("t4_param", bus.NETPARAM,
                    {2'b11, 24'hABCDEF, 32'h00070009, 32'h12345678, 32'h00AA0055});
        popHead();
        checkOutput("t4_popped", bus.NETREQ, 1'b0);

        $display("[TB] FIFO fill and back-pressure");
        for (int k = 1; k <= 4; k++) sendRxFrame(k);
        checkOutput("t5_full_rxrdy", bus.RXRDY, 1'b0);
        bus.RXD   = frameWord(5, 0);
        bus.RXSOF = 1'b1;
        bus.RXVAL = 1'b1;
        tick();
        tick();
        checkOutput("t5_stall_rxrdy", bus.RXRDY,    1'b0);
        checkOutput("t5_head1",       bus.NETPARAM, frameRec(1));
        popHead();
        checkOutput("t5_head2",      bus.NETPARAM, frameRec(2));
        checkOutput("t5_rxrdy_back", bus.RXRDY,    1'b1);
        tick();
        bus.RXVAL = 1'b0;
        bus.RXSOF = 1'b0;
        for (int i = 1; i < 4; i++) sendRxWord(frameWord(5, i), 1'b0);
        checkOutput("t5_refull", bus.RXRDY, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            checkOutput("t5_order", bus.NETPARAM, frameRec(k));
            popHead();
        end
        checkOutput("t5_empty",  bus.NETREQ,   1'b0);
        checkOutput("t5_errcnt", bus.RXERRCNT, 8'h0);

        $display("[TB] restarted frame and transmit overrun");
        sendRxWord(frameWord(7, 0), 1'b1);
        sendRxWord(frameWord(7, 1), 1'b0);
        sendRxFrame(6);
        checkOutput("t6_errcnt", bus.RXERRCNT, 8'h1);
        checkOutput("t6_req",    bus.NETREQ,   1'b1);
        checkOutput("t6_param",  bus.NETPARAM, frameRec(6));
        popHead();
        sendRxWord(32'h12345678, 1'b0);
        checkOutput("t6_stray_errcnt", bus.RXERRCNT, 8'h2);
        checkOutput("t6_stray_noreq",  bus.NETREQ,   1'b0);

        msgA = {32'hA0A0A0A0, 16'h0101, 32'hB1B1B1B1};
        msgB = {32'h5F5F5F5F, 16'hEEEE, 32'h7C7C7C7C};
        checkOutput("t6_ovr_before", bus.TXOVR, 1'b0);
        applyStimulus(msgA, 1'b0, 5'h0);
        tick();
        checkOutput("t6_w1_d", bus.TXD, 32'hB1B1B1B1);
        applyStimulus(msgB, 1'b1, 5'h0A);
        checkOutput("t6_txovr", bus.TXOVR, 1'b1);
        checkOutput("t6_w2_d",  bus.TXD,   32'hA0A0A0A0);
        tick();
        checkOutput("t6_netrdy",     bus.NETRDY, 1'b1);
        checkOutput("t6_ovr_sticky", bus.TXOVR,  1'b1);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
